// File: rtl/iddmm_pkg.sv
// Shared constants and types for the 512-by-256 restoring divider.
package iddmm_pkg;

    localparam int DW_DEF = 512;
    localparam int MW_DEF = 256;

    // Bit n set means n quotient bits per cycle is a supported configuration.
    localparam logic [4:0] BPC_ALLOWED = 5'b10110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit bpc_legal(input int bpc, input int dw);
        return (bpc >= 1) && (bpc <= 4) && BPC_ALLOWED[bpc] && ((dw % bpc) == 0);
    endfunction

endpackage

// File: rtl/iddmm_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module iddmm_div_step #(
    parameter int MW = 256
) (
    input  logic [MW:0]   r,
    input  logic [MW-1:0] m,
    input  logic          bit_in,
    output logic [MW:0]   r_next,
    output logic          qbit
);

    logic [MW:0] shifted;
    logic [MW:0] diff;

    // r < m on entry, so the shifted value is < 2m and fits in MW+1 bits.
    assign shifted = {r[MW-1:0], bit_in};
    assign diff    = shifted - {1'b0, m};
    assign qbit    = (shifted >= {1'b0, m});
    assign r_next  = qbit ? diff : shifted;

endmodule

// File: rtl/iddmm_div_512_by_256.sv
// Sequential restoring divider: DW-bit dividend by MW-bit divisor, BPC quotient bits per cycle.
module iddmm_div_512_by_256
    import iddmm_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int MW  = MW_DEF,
    parameter int BPC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] x,
    input  logic [MW-1:0] m,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] quotient,
    output logic [MW-1:0] remainder,
    output logic          div0
);

    localparam int STEPS = DW / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    if (!bpc_legal(BPC, DW)) begin : g_bpc_illegal
        $error("iddmm_div_512_by_256: BPC must be 1, 2 or 4 and divide DW");
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] xsh;
    logic [MW-1:0] m_r;
    logic [MW:0]   r_q;
    logic [MW:0]   r_chain [0:BPC];
    logic [BPC-1:0] qbits;
    logic [DW-1:0] xsh_nxt;
    logic          accept;
    logic          last;

    // xsh doubles as the quotient register: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    assign r_chain[0] = r_q;
    for (genvar k = 0; k < BPC; k++) begin : g_step
        iddmm_div_step #(.MW(MW)) u_step (
            .r      (r_chain[k]),
            .m      (m_r),
            .bit_in (xsh[DW-1-k]),
            .r_next (r_chain[k+1]),
            .qbit   (qbits[BPC-1-k])
        );
    end

    assign xsh_nxt = {xsh[DW-BPC-1:0], qbits};
    assign accept  = i_valid && i_ready;
    assign last    = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_nxt = (m == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            xsh       <= '0;
            m_r       <= '0;
            r_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xsh <= x;
                        m_r <= m;
                        r_q <= '0;
                        cnt <= CW'(STEPS);
                        if (m == '0) begin
                            quotient  <= '1;
                            remainder <= x[MW-1:0];
                            div0      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    xsh <= xsh_nxt;
                    r_q <= r_chain[BPC];
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        quotient  <= xsh_nxt;
                        remainder <= r_chain[BPC][MW-1:0];
                        div0      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iddmm_div_512_by_256.sv
// Scoreboard bench for the divider, run on BPC=1/2/4 instances fed identical operands.
module tb_iddmm_div_512_by_256;

    localparam int DW = 512;
    localparam int MW = 256;
    localparam int BPCV [3] = '{1, 2, 4};
    localparam int BOUND = 3000;

    typedef struct {
        logic [DW-1:0] q;
        logic [MW-1:0] r;
        logic          d0;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b1;
    logic [DW-1:0] x = '0;
    logic [MW-1:0] m = '0;

    logic          ir  [3];
    logic          ov  [3];
    logic          d0o [3];
    logic [DW-1:0] qo  [3];
    logic [MW-1:0] ro  [3];

    exp_t sb [3][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc [3];
    int   lat_obs [3];
    bit   seen [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iddmm_div_512_by_256 #(.DW(DW), .MW(MW), .BPC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[0]), .x(x), .m(m),
        .o_valid(ov[0]), .o_ready(o_ready), .quotient(qo[0]), .remainder(ro[0]), .div0(d0o[0]));
    iddmm_div_512_by_256 #(.DW(DW), .MW(MW), .BPC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[1]), .x(x), .m(m),
        .o_valid(ov[1]), .o_ready(o_ready), .quotient(qo[1]), .remainder(ro[1]), .div0(d0o[1]));
    iddmm_div_512_by_256 #(.DW(DW), .MW(MW), .BPC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[2]), .x(x), .m(m),
        .o_valid(ov[2]), .o_ready(o_ready), .quotient(qo[2]), .remainder(ro[2]), .div0(d0o[2]));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Monitor: pops one expectation per output handshake, also checks latency.
    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                seen[k] = 1'b0;
            end else begin
                if (i_valid && ir[k]) acc[k] = cyc + 1;
                if (ov[k] && !seen[k]) begin
                    seen[k]    = 1'b1;
                    lat_obs[k] = cyc - acc[k] + 1;
                end
                if (ov[k] && o_ready) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output bpc%0d: got o_valid=1 want none", BPCV[k]);
                    end else begin
                        exp_t e;
                        e = sb[k].pop_front();
                        chk($sformatf("quotient bpc%0d", BPCV[k]), qo[k], e.q);
                        chk($sformatf("remainder bpc%0d", BPCV[k]), DW'(ro[k]), DW'(e.r));
                        chk($sformatf("div0 bpc%0d", BPCV[k]), DW'(d0o[k]), DW'(e.d0));
                        chk($sformatf("latency bpc%0d", BPCV[k]), DW'(lat_obs[k]), DW'(e.lat));
                    end
                    seen[k] = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: got i_ready low want high");
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] qv, input logic [MW-1:0] rv, input logic dv);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.q   = qv;
            e.r   = rv;
            e.d0  = dv;
            e.lat = dv ? 1 : 1 + DW / BPCV[k];
            sb[k].push_back(e);
        end
    endtask

    task automatic issue(input logic [DW-1:0] xv, input logic [MW-1:0] mv,
                         input logic [DW-1:0] qv, input logic [MW-1:0] rv, input logic dv);
        wait_idle();
        x       = xv;
        m       = mv;
        i_valid = 1'b1;
        push_exp(qv, rv, dv);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= BOUND) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: got pending results want none");
            for (int k = 0; k < 3; k++) sb[k].delete();
        end
    endtask

    function automatic logic [MW-1:0] rnd256();
        logic [MW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] big_q;
        logic [DW-1:0] pat;
        logic [DW-1:0] sq;
        logic [MW-1:0] sr;
        logic [MW-1:0] a, b, r;
        logic [DW-1:0] xv;
        int n;

        repeat (3) @(negedge clk);
        chk("reset i_ready", DW'(ir[0]), DW'(1));
        chk("reset o_valid", DW'(ov[0]), DW'(0));
        chk("reset quotient", qo[0], '0);
        chk("reset remainder", DW'(ro[0]), '0);
        chk("reset div0", DW'(d0o[0]), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        big_q = (DW'(1) << 256) + DW'(1);
        pat   = {16{32'hDEADBEEF}};
        issue(DW'(100), MW'(7), DW'(14), MW'(2), 1'b0);                 drain();
        issue('1, '1, big_q, '0, 1'b0);                                 drain();
        issue(DW'(16'h1234), '0, '1, MW'(16'h1234), 1'b1);              drain();
        issue(DW'(5), '1, '0, MW'(5), 1'b0);                            drain();
        issue(pat, MW'(1), pat, '0, 1'b0);                              drain();
        issue('0, MW'(12345), '0, '0, 1'b0);                            drain();
        issue({16{32'hA5A55A5A}}, '0, '1, {8{32'hA5A55A5A}}, 1'b1);     drain();
        issue(DW'(1000), MW'(10), DW'(100), '0, 1'b0);                  drain();

        // Backpressure with a competing request held during DONE
        o_ready = 1'b0;
        issue(DW'(100), MW'(7), DW'(14), MW'(2), 1'b0);
        n = 0;
        while (!ov[0] && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("bp o_valid reached", DW'(ov[0]), DW'(1));
        x       = DW'(1000);
        m       = MW'(10);
        i_valid = 1'b1;
        push_exp(DW'(100), '0, 1'b0);
        sq = qo[0];
        sr = ro[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp o_valid held", DW'(ov[0]), DW'(1));
            chk("bp i_ready low", DW'(ir[0]), DW'(0));
            chk("bp quotient stable", qo[0], sq);
            chk("bp remainder stable", DW'(ro[0]), DW'(sr));
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk("post-hs i_ready", DW'(ir[0]), DW'(1));
        chk("post-hs o_valid", DW'(ov[0]), DW'(0));
        @(negedge clk);
        chk("held request accepted", DW'(ir[0]), DW'(0));
        i_valid = 1'b0;
        drain();

        // Random a*b+r with r<b
        for (int it = 0; it < 100; it++) begin
            a = rnd256();
            b = rnd256() >> $urandom_range(0, 255);
            if (b == '0) b = MW'(1);
            r = rnd256() % b;
            xv = {{MW{1'b0}}, a} * {{MW{1'b0}}, b} + {{MW{1'b0}}, r};
            issue(xv, b, {{MW{1'b0}}, a}, r, 1'b0);
            drain();
        end

        // Reset in the middle of a calculation
        issue(DW'(100), MW'(7), DW'(14), MW'(2), 1'b0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort o_valid bpc%0d", BPCV[k]), DW'(ov[k]), DW'(0));
            chk($sformatf("abort i_ready bpc%0d", BPCV[k]), DW'(ir[k]), DW'(1));
            sb[k].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(DW'(100), MW'(7), DW'(14), MW'(2), 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
